// File: rtl/transpose_pkg.sv
// Shared definitions for the transpose B-matrix streamer: FSM encoding,
// a constant clog2 and the geometry check used at elaboration.
package transpose_pkg;

  // Streamer FSM; the encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAITXP  = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAITRSP = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  localparam int ROW_IDX_W = 16;
  localparam int ADDR_W    = 32;

  // Ceiling log2 with a floor of 1 so it can size 1-entry counters.
  function automatic int clog2(input int value);
    int r;
    for (r = 1; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  // A row of B must split into whole beats.
  function automatic bit cols_fit(input int cols, input int lanes);
    return (lanes > 0) && ((cols % lanes) == 0);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous beat FIFO with count output. Head is presented directly from
// storage so the output beat stays stable while the consumer stalls.
// A push is accepted on a full FIFO only when a pop happens in the same cycle.
module stream_fifo
  import transpose_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            head_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/transpose_b_streamer.sv
// Reads matrix B element by element through the transpose controller's
// B-read port, packs LANES consecutive columns into a beat and streams the
// beats row-major through a small FIFO.
//
// Handshakes: a beat moves when m_valid && m_ready are both high on a rising
// clk edge; m_valid never depends on m_ready and the head beat is held until
// it moves. On the B port, rd_re is a one-cycle request with rd_row/rd_col
// held until the matching rd_rvalid; only one request is ever outstanding.
module transpose_b_streamer
  import transpose_pkg::*;
#(
  parameter int B_ROWS     = 64,
  parameter int B_COLS     = 64,
  parameter int DATA_W     = 32,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    xp_busy,
  output logic                    rd_re,
  output logic [ADDR_W-1:0]       rd_row,
  output logic [ADDR_W-1:0]       rd_col,
  input  logic [DATA_W-1:0]       rd_rdata,
  input  logic                    rd_rvalid,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [LANES*DATA_W-1:0] m_data,
  output logic                    m_last,
  output logic [ROW_IDX_W-1:0]    m_row,
  output logic [2:0]              dbg_state_o
);

  localparam int LANE_W  = clog2(LANES);
  localparam int BEAT_W  = LANES * DATA_W;
  localparam int ENTRY_W = ROW_IDX_W + 1 + BEAT_W;
  localparam int CNT_W   = clog2(FIFO_DEPTH + 1);

  if (!cols_fit(B_COLS, LANES)) begin : g_cfg_err
    $error("transpose_b_streamer: B_COLS must be a multiple of LANES");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d, col_q, col_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [BEAT_W-1:0]   pack_q, pack_d;
  logic                rd_re_q, rd_re_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                push, pop;
  logic [ENTRY_W-1:0]  push_data, fifo_head;
  logic                fifo_empty, fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic                row_end, last_elem;

  assign row_end   = (col_q == ADDR_W'(B_COLS - 1));
  assign last_elem = row_end && (row_q == ADDR_W'(B_ROWS - 1));
  assign push_data = {row_q[ROW_IDX_W-1:0], row_end, pack_d};

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign {m_row, m_last, m_data} = fifo_head;

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_re       = rd_re_q;
  assign rd_row      = row_q;
  assign rd_col      = col_q;
  assign dbg_state_o = state_q;

  stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // State, address walk, pack register and registered port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      rd_re_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      rd_re_q <= rd_re_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: request issue, response capture, beat push and completion.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lane_d  = lane_q;
    pack_d  = pack_q;
    rd_re_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    push    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAITXP;
          busy_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          lane_d  = '0;
          pack_d  = '0;
        end
      end

      S_WAITXP: begin
        if (!xp_busy) state_d = S_ISSUE;
      end

      S_ISSUE: begin
        // Starting a beat claims a FIFO slot up front; nothing else pushes
        // until that beat is complete, so the push can never hit a full FIFO.
        if (!xp_busy && ((lane_q != '0) || !fifo_full)) begin
          rd_re_d = 1'b1;
          state_d = S_WAITRSP;
        end
      end

      S_WAITRSP: begin
        if (xp_busy) begin
          // The engine took the port back: treat the request as lost and
          // re-issue the same element once the port is free again.
          state_d = S_ISSUE;
        end else if (rd_rvalid) begin
          pack_d[int'(lane_q)*DATA_W +: DATA_W] = rd_rdata;
          if (lane_q == LANE_W'(LANES - 1)) begin
            push   = 1'b1;
            lane_d = '0;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
          if (last_elem) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
            if (row_end) begin
              col_d = '0;
              row_d = row_q + ADDR_W'(1);
            end else begin
              col_d = col_q + ADDR_W'(1);
            end
          end
        end
      end

      S_DRAIN: begin
        if (fifo_empty || ((fifo_count == CNT_W'(1)) && pop)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_transpose_b_streamer.sv
// Directed bench for transpose_b_streamer. Instance A: 4x4, LANES=4.
// Instance C: 8x8, LANES=2. Both use FIFO_DEPTH=4 and a B-port responder
// with configurable latency; elements are B[r][c] = r*16+c (C adds 0xB0000000).
module tb_transpose_b_streamer;

  localparam int W_A = 16 + 1 + 4 * 32;
  localparam int W_C = 16 + 1 + 2 * 32;

  logic         clk, rst_n;

  logic         start_a, busy_a, done_a, xp_busy_a, rd_re_a, rd_rvalid_a;
  logic         m_valid_a, m_ready_a, m_last_a;
  logic [31:0]  rd_row_a, rd_col_a, rd_rdata_a;
  logic [127:0] m_data_a;
  logic [15:0]  m_row_a;
  logic [2:0]   dbg_a;

  logic         start_c, busy_c, done_c, xp_busy_c, rd_re_c, rd_rvalid_c;
  logic         m_valid_c, m_ready_c, m_last_c;
  logic [31:0]  rd_row_c, rd_col_c, rd_rdata_c;
  logic [63:0]  m_data_c;
  logic [15:0]  m_row_c;
  logic [2:0]   dbg_c;

  logic [W_A-1:0] got_a[$], exp_a[$];
  logic [W_C-1:0] got_c[$], exp_c[$];
  logic [31:0]    req_a[$];

  int   vec_cnt, err_cnt, cyc;
  int   reads_a, reads_c, done_cnt_a, done_cnt_c;
  int   done_cyc_a, done_cyc_c, pop_cyc_a, pop_cyc_c;
  logic busy_at_done_a, busy_at_done_c;
  int   rmode_a, rmode_c, lat_a, lat_c;
  bit   pend_a, pend_c;
  int   cnt_a, cnt_c, prow_a, pcol_a, prow_c, pcol_c;

  transpose_b_streamer #(
    .B_ROWS(4), .B_COLS(4), .DATA_W(32), .LANES(4), .FIFO_DEPTH(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .xp_busy(xp_busy_a), .rd_re(rd_re_a), .rd_row(rd_row_a), .rd_col(rd_col_a),
    .rd_rdata(rd_rdata_a), .rd_rvalid(rd_rvalid_a), .m_valid(m_valid_a),
    .m_ready(m_ready_a), .m_data(m_data_a), .m_last(m_last_a), .m_row(m_row_a),
    .dbg_state_o(dbg_a)
  );

  transpose_b_streamer #(
    .B_ROWS(8), .B_COLS(8), .DATA_W(32), .LANES(2), .FIFO_DEPTH(4)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
    .xp_busy(xp_busy_c), .rd_re(rd_re_c), .rd_row(rd_row_c), .rd_col(rd_col_c),
    .rd_rdata(rd_rdata_c), .rd_rvalid(rd_rvalid_c), .m_valid(m_valid_c),
    .m_ready(m_ready_c), .m_data(m_data_c), .m_last(m_last_c), .m_row(m_row_c),
    .dbg_state_o(dbg_c)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic logic [31:0] elem_a(input int r, input int c);
    return 32'(r * 16 + c);
  endfunction

  function automatic logic [31:0] elem_c(input int r, input int c);
    return 32'hB000_0000 | 32'(r * 16 + c);
  endfunction

  task automatic build_exp_a();
    logic [127:0] d;
    exp_a.delete();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) d[k*32 +: 32] = elem_a(r, k);
      exp_a.push_back({16'(r), 1'b1, d});
    end
  endtask

  task automatic build_exp_c();
    logic [63:0] d;
    exp_c.delete();
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < 2; k++) d[k*32 +: 32] = elem_c(r, b * 2 + k);
        exp_c.push_back({16'(r), 1'(b == 3), d});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: sample outputs #1 after the edge, record pops/done, run the
  // B-port responders, then set inputs for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; busy_at_done_a = busy_a; end
    if (done_c) begin done_cnt_c++; done_cyc_c = cyc; busy_at_done_c = busy_c; end

    case (rmode_a)
      0:       m_ready_a = 1'b0;
      1:       m_ready_a = 1'b1;
      default: m_ready_a = 1'($urandom_range(0, 1));
    endcase
    case (rmode_c)
      0:       m_ready_c = 1'b0;
      1:       m_ready_c = 1'b1;
      default: m_ready_c = 1'($urandom_range(0, 1));
    endcase
    if (m_valid_a && m_ready_a) begin
      got_a.push_back({m_row_a, m_last_a, m_data_a});
      pop_cyc_a = cyc;
    end
    if (m_valid_c && m_ready_c) begin
      got_c.push_back({m_row_c, m_last_c, m_data_c});
      pop_cyc_c = cyc;
    end

    rd_rvalid_a = 1'b0;
    if (rd_re_a) begin
      reads_a++;
      req_a.push_back({rd_row_a[15:0], rd_col_a[15:0]});
      pend_a = 1'b1;
      cnt_a  = (lat_a == 0) ? int'($urandom_range(1, 5)) : lat_a;
      prow_a = int'(rd_row_a);
      pcol_a = int'(rd_col_a);
    end
    if (pend_a) begin
      if (cnt_a <= 1) begin
        rd_rvalid_a = 1'b1;
        rd_rdata_a  = elem_a(prow_a, pcol_a);
        pend_a      = 1'b0;
      end else cnt_a--;
    end

    rd_rvalid_c = 1'b0;
    if (rd_re_c) begin
      reads_c++;
      pend_c = 1'b1;
      cnt_c  = (lat_c == 0) ? int'($urandom_range(1, 5)) : lat_c;
      prow_c = int'(rd_row_c);
      pcol_c = int'(rd_col_c);
    end
    if (pend_c) begin
      if (cnt_c <= 1) begin
        rd_rvalid_c = 1'b1;
        rd_rdata_c  = elem_c(prow_c, pcol_c);
        pend_c      = 1'b0;
      end else cnt_c--;
    end
  endtask

  task automatic clr();
    got_a.delete(); req_a.delete(); got_c.delete();
    reads_a = 0; reads_c = 0; done_cnt_a = 0; done_cnt_c = 0;
    done_cyc_a = -1; done_cyc_c = -1; pop_cyc_a = -1; pop_cyc_c = -1;
    busy_at_done_a = 1'b1; busy_at_done_c = 1'b1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic run_a(input int budget);
    for (int i = 0; i < budget && done_cnt_a == 0; i++) step();
    repeat (3) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [212:0] outs_a;
    logic [148:0] outs_c;
    repeat (2) step();
    outs_a = {busy_a, done_a, rd_re_a, m_valid_a, m_last_a, m_row_a, rd_row_a, rd_col_a, m_data_a};
    outs_c = {busy_c, done_c, rd_re_c, m_valid_c, m_last_c, m_row_c, rd_row_c, rd_col_c, m_data_c};
    vec_cnt++;
    if (outs_a !== '0) begin err_cnt++; $display("FAIL reset_outs_a: got %h exp 0", outs_a); end
    vec_cnt++;
    if (outs_c !== '0) begin err_cnt++; $display("FAIL reset_outs_c: got %h exp 0", outs_c); end
    vec_cnt++;
    if (dbg_a !== 3'd0) begin err_cnt++; $display("FAIL reset_state_a: got %0d exp 0", dbg_a); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [W_A-1:0] b1;
    clr(); build_exp_a(); rmode_a = 1; lat_a = 1;
    pulse_start_a();
    vec_cnt++;
    if (busy_a !== 1'b1) begin err_cnt++; $display("FAIL stream_busy: got %b exp 1", busy_a); end
    repeat (4) step();
    pulse_start_a();
    run_a(400);
    vec_cnt++;
    if (got_a.size() != 4) begin err_cnt++; $display("FAIL stream_beats: got %0d exp 4", got_a.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      vec_cnt++;
      if (i >= got_a.size()) begin
        err_cnt++; $display("FAIL stream_beat[%0d]: got none exp %h", i, exp_a[i]);
      end else if (got_a[i] !== exp_a[i]) begin
        err_cnt++; $display("FAIL stream_beat[%0d]: got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
    b1 = (got_a.size() > 1) ? got_a[1] : '0;
    vec_cnt++;
    if (b1[127:0] !== 128'h00000013_00000012_00000011_00000010) begin
      err_cnt++; $display("FAIL stream_beat1_lanes: got %h exp 00000013000000120000001100000010", b1[127:0]);
    end
    vec_cnt++;
    if (done_cnt_a != 1) begin err_cnt++; $display("FAIL stream_done_count: got %0d exp 1", done_cnt_a); end
    vec_cnt++;
    if (done_cyc_a != pop_cyc_a + 1) begin
      err_cnt++; $display("FAIL stream_done_timing: got cycle %0d exp %0d", done_cyc_a, pop_cyc_a + 1);
    end
    vec_cnt++;
    if (busy_at_done_a !== 1'b0) begin err_cnt++; $display("FAIL stream_busy_at_done: got %b exp 0", busy_at_done_a); end
  endtask

  task automatic test_backpressure();
    logic [W_C-1:0] head_c;
    clr(); build_exp_a(); build_exp_c();
    rmode_a = 0; rmode_c = 0; lat_a = 2; lat_c = 2;
    start_a = 1'b1; start_c = 1'b1;
    step();
    start_a = 1'b0; start_c = 1'b0;
    repeat (200) step();
    vec_cnt++;
    if (reads_a != 16) begin err_cnt++; $display("FAIL bp_reads_a: got %0d exp 16", reads_a); end
    vec_cnt++;
    if (reads_c != 8) begin err_cnt++; $display("FAIL bp_reads_c: got %0d exp 8", reads_c); end
    vec_cnt++;
    if (m_valid_a !== 1'b1 || got_a.size() != 0) begin
      err_cnt++; $display("FAIL bp_hold_a: got valid=%b pops=%0d exp valid=1 pops=0", m_valid_a, got_a.size());
    end
    head_c = {m_row_c, m_last_c, m_data_c};
    vec_cnt++;
    if (head_c !== exp_c[0]) begin err_cnt++; $display("FAIL bp_head_c: got %h exp %h", head_c, exp_c[0]); end
    rmode_a = 1; rmode_c = 1;
    for (int i = 0; i < 1500 && (done_cnt_a == 0 || done_cnt_c == 0); i++) step();
    repeat (3) step();
    vec_cnt++;
    if (done_cnt_a != 1 || done_cnt_c != 1) begin
      err_cnt++; $display("FAIL bp_done: got a=%0d c=%0d exp 1 1", done_cnt_a, done_cnt_c);
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      vec_cnt++;
      if (i >= got_a.size()) begin
        err_cnt++; $display("FAIL bp_beat_a[%0d]: got none exp %h", i, exp_a[i]);
      end else if (got_a[i] !== exp_a[i]) begin
        err_cnt++; $display("FAIL bp_beat_a[%0d]: got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
    for (int i = 0; i < exp_c.size(); i++) begin
      vec_cnt++;
      if (i >= got_c.size()) begin
        err_cnt++; $display("FAIL bp_beat_c[%0d]: got none exp %h", i, exp_c[i]);
      end else if (got_c[i] !== exp_c[i]) begin
        err_cnt++; $display("FAIL bp_beat_c[%0d]: got %h exp %h", i, got_c[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_xp_wait();
    logic [31:0] first;
    clr(); build_exp_a(); rmode_a = 1; lat_a = 3;
    xp_busy_a = 1'b1;
    pulse_start_a();
    repeat (20) step();
    vec_cnt++;
    if (reads_a != 0) begin err_cnt++; $display("FAIL xpwait_no_reads: got %0d exp 0", reads_a); end
    vec_cnt++;
    if (dbg_a !== 3'd1) begin err_cnt++; $display("FAIL xpwait_state: got %0d exp 1", dbg_a); end
    xp_busy_a = 1'b0;
    run_a(400);
    first = (req_a.size() > 0) ? req_a[0] : 32'hFFFF_FFFF;
    vec_cnt++;
    if (first !== 32'h0) begin err_cnt++; $display("FAIL xpwait_first_req: got %h exp 00000000", first); end
    for (int i = 0; i < exp_a.size(); i++) begin
      vec_cnt++;
      if (i >= got_a.size()) begin
        err_cnt++; $display("FAIL xpwait_beat[%0d]: got none exp %h", i, exp_a[i]);
      end else if (got_a[i] !== exp_a[i]) begin
        err_cnt++; $display("FAIL xpwait_beat[%0d]: got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_xp_abort();
    bit found;
    int n12;
    clr(); build_exp_a(); rmode_a = 1; lat_a = 4;
    pulse_start_a();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (rd_re_a && rd_row_a == 32'd1 && rd_col_a == 32'd2) found = 1'b1;
    end
    vec_cnt++;
    if (!found) begin err_cnt++; $display("FAIL abort_req12_seen: got 0 exp 1"); end
    // Raise xp_busy while (1,2) is outstanding; the old response lands inside this window.
    xp_busy_a = 1'b1;
    repeat (5) step();
    vec_cnt++;
    if (dbg_a !== 3'd2) begin err_cnt++; $display("FAIL abort_state: got %0d exp 2", dbg_a); end
    xp_busy_a = 1'b0;
    run_a(400);
    n12 = 0;
    foreach (req_a[i]) if (req_a[i] == 32'h0001_0002) n12++;
    vec_cnt++;
    if (n12 != 2) begin err_cnt++; $display("FAIL abort_reissue: got %0d requests for (1,2) exp 2", n12); end
    vec_cnt++;
    if (reads_a != 17) begin err_cnt++; $display("FAIL abort_reads: got %0d exp 17", reads_a); end
    for (int i = 0; i < exp_a.size(); i++) begin
      vec_cnt++;
      if (i >= got_a.size()) begin
        err_cnt++; $display("FAIL abort_beat[%0d]: got none exp %h", i, exp_a[i]);
      end else if (got_a[i] !== exp_a[i]) begin
        err_cnt++; $display("FAIL abort_beat[%0d]: got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [212:0] outs_a;
    logic [31:0]  first;
    clr(); build_exp_a(); rmode_a = 1; lat_a = 2;
    pulse_start_a();
    for (int i = 0; i < 200 && reads_a < 2; i++) step();
    vec_cnt++;
    if (reads_a != 2) begin err_cnt++; $display("FAIL rstmid_reads: got %0d exp 2", reads_a); end
    rst_n = 1'b0;
    pend_a = 1'b0;
    rd_rvalid_a = 1'b0;
    step();
    outs_a = {busy_a, done_a, rd_re_a, m_valid_a, m_last_a, m_row_a, rd_row_a, rd_col_a, m_data_a};
    vec_cnt++;
    if (outs_a !== '0 || dbg_a !== 3'd0) begin
      err_cnt++; $display("FAIL rstmid_outs: got %h state %0d exp 0 state 0", outs_a, dbg_a);
    end
    rst_n = 1'b1;
    step();
    clr(); build_exp_a();
    pulse_start_a();
    run_a(400);
    first = (req_a.size() > 0) ? req_a[0] : 32'hFFFF_FFFF;
    vec_cnt++;
    if (first !== 32'h0) begin err_cnt++; $display("FAIL rstmid_first_req: got %h exp 00000000", first); end
    for (int i = 0; i < exp_a.size(); i++) begin
      vec_cnt++;
      if (i >= got_a.size()) begin
        err_cnt++; $display("FAIL rstmid_beat[%0d]: got none exp %h", i, exp_a[i]);
      end else if (got_a[i] !== exp_a[i]) begin
        err_cnt++; $display("FAIL rstmid_beat[%0d]: got %h exp %h", i, got_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_random();
    int lasts;
    clr(); build_exp_c(); rmode_c = 2; lat_c = 0;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    for (int i = 0; i < 4000 && done_cnt_c == 0; i++) step();
    repeat (3) step();
    vec_cnt++;
    if (got_c.size() != 32) begin err_cnt++; $display("FAIL rand_beats: got %0d exp 32", got_c.size()); end
    for (int i = 0; i < exp_c.size(); i++) begin
      vec_cnt++;
      if (i >= got_c.size()) begin
        err_cnt++; $display("FAIL rand_beat[%0d]: got none exp %h", i, exp_c[i]);
      end else if (got_c[i] !== exp_c[i]) begin
        err_cnt++; $display("FAIL rand_beat[%0d]: got %h exp %h", i, got_c[i], exp_c[i]);
      end
    end
    lasts = 0;
    foreach (got_c[i]) if (got_c[i][64]) lasts++;
    vec_cnt++;
    if (lasts != 8) begin err_cnt++; $display("FAIL rand_last_count: got %0d exp 8", lasts); end
    vec_cnt++;
    if (done_cnt_c != 1 || done_cyc_c != pop_cyc_c + 1) begin
      err_cnt++; $display("FAIL rand_done: got count %0d cycle %0d exp 1 cycle %0d", done_cnt_c, done_cyc_c, pop_cyc_c + 1);
    end
    vec_cnt++;
    if (busy_at_done_c !== 1'b0) begin err_cnt++; $display("FAIL rand_busy_at_done: got %b exp 0", busy_at_done_c); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vec_cnt = 0; err_cnt = 0; cyc = 0;
    rst_n = 1'b0;
    start_a = 1'b0; xp_busy_a = 1'b0; rd_rvalid_a = 1'b0; rd_rdata_a = '0; m_ready_a = 1'b0;
    start_c = 1'b0; xp_busy_c = 1'b0; rd_rvalid_c = 1'b0; rd_rdata_c = '0; m_ready_c = 1'b0;
    rmode_a = 0; rmode_c = 0; lat_a = 1; lat_c = 1;
    pend_a = 1'b0; pend_c = 1'b0; cnt_a = 0; cnt_c = 0;
    prow_a = 0; pcol_a = 0; prow_c = 0; pcol_c = 0;
    clr();

    test_reset();
    test_stream();
    test_backpressure();
    test_xp_wait();
    test_xp_abort();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
